mod107_residue_accum: RTL and testbench
=======================================

Name: mod107_residue_accum

Overview:
- Sequential consumer for the mod-107 reduction of 500-bit operands.
- The 6-bit-chunk LUT stages each turn one chunk into a 7-bit partial residue. This block takes those partial residues as a valid/ready stream, one frame per operand.
- It adds them modulo 107 and returns the final 7-bit residue of the full operand with frame and range error flags.
- It sits directly downstream of the chunk-LUT bank, or its serialiser, in the modular-calc datapath.

Parameters:
- MODULUS, 107, modulus; must be < 2^RES_W.
- RES_W, 7, width of partial and final residues.
- NUM_CHUNKS, 84, expected beats per frame (ceil(500/6)).
- CNT_W, 7, beat-counter width; must hold NUM_CHUNKS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  partial residue present.
- in_ready  out  1  block accepts a beat.
- in_residue  in  RES_W  partial residue, nominally 0..MODULUS-1.
- in_last  in  1  final beat of frame.
- out_valid  out  1  final residue available.
- out_ready  in  1  consumer takes result.
- out_residue  out  RES_W  sum of frame residues mod MODULUS.
- out_len_err  out  1  frame beat count != NUM_CHUNKS.
- out_range_err  out  1  at least one beat had in_residue >= MODULUS.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - state=IDLE, acc=0, cnt=0, sticky errors=0.
  - out_valid=0, out_residue=0, out_len_err=0, out_range_err=0.
  - in_ready=1 from the first cycle after reset.
  - A reset mid-frame discards the partial frame with no output.
- States: IDLE (no beat yet), ACCUM (frame open), DONE (result held).
- in_ready = 1 in IDLE/ACCUM, 0 in DONE.
- Beat accept = in_valid & in_ready.
- Per accepted beat:
  - r = in_residue >= MODULUS ? in_residue-MODULUS : in_residue.
  - On the out-of-range case, set sticky range_err.
  - s = acc + r, using RES_W+1 bits.
  - acc_next = s >= MODULUS ? s-MODULUS : s. Result is always 0..MODULUS-1.
- Counter:
  - cnt increments per beat and saturates at 2^CNT_W-1.
  - Beat count = cnt+1 on the last beat.
- IDLE -> ACCUM on an accepted beat with in_last=0.
- IDLE or ACCUM -> DONE on an accepted beat with in_last=1:
  - Same edge: out_residue=acc_next, out_valid=1.
  - out_len_err = (cnt+1 != NUM_CHUNKS).
  - out_range_err = sticky range_err, including the current beat.
  - Latency: last beat accepted in cycle N -> out_valid high in cycle N+1.
  - One-beat frame is legal: result = reduced in_residue, len_err=1 unless NUM_CHUNKS=1.
- DONE:
  - All outputs held stable while out_ready=0.
  - On out_valid & out_ready -> IDLE; acc, cnt and sticky errors clear on the same edge.
  - in_ready rises the following cycle: one bubble per frame, by design.
- More than NUM_CHUNKS beats before in_last: keep accumulating, len_err reported at frame end.
- in_valid without in_last in DONE is ignored, since in_ready=0.
- Source must hold in_residue/in_last stable while in_valid & !in_ready.

Decomposition:
- Package mod107_pkg:
  - localparams MODULUS, RES_W, NUM_CHUNKS, CNT_W.
  - typedef residue_t (logic [RES_W-1:0]).
  - enum state_t {IDLE, ACCUM, DONE}.
- Sub-module mod107_add:
  - Combinational a+b mod MODULUS for a < MODULUS, b < 2^RES_W.
  - Includes the pre-reduction of b and a range flag output.
  - Reused by later accumulate/compare blocks.
- The top holds the FSM, counter, sticky flags and output register.

Test Plan:
- 84 beats of 1, last on beat 84, out_ready=1 -> out_residue=84, len_err=0, range_err=0, out_valid one cycle after last.
- 84 beats of 106 -> out_residue=23 (−84 mod 107), no errors.
- 3-beat frame 50,60,100 with last -> out_residue=103, out_len_err=1, range_err=0.
- 84-beat frame, all 0 except one beat of 120 -> out_residue=13, out_range_err=1, len_err=0.
- Result ready, out_ready low 5 cycles -> out_residue/errors stable, in_ready=0, beats offered are not consumed; out_ready high -> IDLE, next frame of 84×2 gives 61.
- 10 beats of 5, then rst for 1 cycle, then 84 beats of 1 -> no output for the aborted frame, then out_residue=84, no errors.

Source files
------------

// File: rtl/mod107_pkg.sv
// Shared constants and types for the mod-107 residue datapath.
// Imported by the adder and the frame accumulator.
package mod107_pkg;

  localparam int MODULUS    = 107;
  localparam int RES_W      = 7;
  localparam int NUM_CHUNKS = 84;
  localparam int CNT_W      = 7;

  typedef logic [RES_W-1:0] residue_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/mod107_add.sv
// Combinational (a + b) mod MODULUS, a already reduced, b any RES_W value.
// b is folded once before the add; range_o flags b >= MODULUS.
module mod107_add
  import mod107_pkg::*;
(
  input  residue_t a_i,
  input  residue_t b_i,
  output residue_t sum_o,
  output logic     range_o
);

  localparam logic [RES_W:0] MOD_W = (RES_W+1)'(MODULUS);

  logic [RES_W:0] b_ext;
  logic [RES_W:0] b_red;
  logic [RES_W:0] s;

  assign b_ext   = {1'b0, b_i};
  assign range_o = b_ext >= MOD_W;
  assign b_red   = range_o ? b_ext - MOD_W : b_ext;
  assign s       = {1'b0, a_i} + b_red;
  assign sum_o   = residue_t'(s >= MOD_W ? s - MOD_W : s);

endmodule

// File: rtl/mod107_residue_accum.sv
// Frame accumulator: sums a stream of partial residues mod 107 and
// reports the final residue with length and range error flags.
module mod107_residue_accum
  import mod107_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_residue,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_residue,
  output logic             out_len_err,
  output logic             out_range_err
);

  localparam logic [CNT_W:0] NUM_W = (CNT_W+1)'(NUM_CHUNKS);

  state_t             state_q, state_d;
  residue_t           acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rng_q, rng_d;
  residue_t           res_q, res_d;
  logic               vld_q, vld_d;
  logic               len_q, len_d;
  logic               rerr_q, rerr_d;

  residue_t           sum;
  logic               beat_rng;
  logic               accept;
  logic [CNT_W:0]     beats;
  logic [CNT_W-1:0]   cnt_sat;

  mod107_add u_add (
    .a_i     (acc_q),
    .b_i     (in_residue),
    .sum_o   (sum),
    .range_o (beat_rng)
  );

  assign in_ready = (state_q != DONE);
  assign accept   = in_valid & in_ready;
  assign beats    = {1'b0, cnt_q} + 1'b1;
  assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rng_d   = rng_q;
    res_d   = res_q;
    vld_d   = vld_q;
    len_d   = len_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_sat;
          rng_d = rng_q | beat_rng;
          if (in_last) begin
            state_d = DONE;
            res_d   = sum;
            vld_d   = 1'b1;
            len_d   = (beats != NUM_W);
            rerr_d  = rng_q | beat_rng;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        // Handshake closes the frame; in_ready returns next cycle.
        if (out_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          rng_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rng_q   <= 1'b0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      len_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rng_q   <= rng_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      len_q   <= len_d;
      rerr_q  <= rerr_d;
    end
  end

  assign out_valid     = vld_q;
  assign out_residue   = res_q;
  assign out_len_err   = len_q;
  assign out_range_err = rerr_q;

endmodule

// File: tb/tb_mod107_residue_accum.sv
// Scoreboard bench for mod107_residue_accum: stimulus pushes expected
// results, a negedge monitor pops them on each output handshake.
module tb_mod107_residue_accum;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_residue;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_residue;
  logic       out_len_err;
  logic       out_range_err;

  typedef struct {
    int res;
    int len;
    int rng;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   popped   = 0;

  mod107_residue_accum dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_residue    (in_residue),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_residue   (out_residue),
    .out_len_err   (out_len_err),
    .out_range_err (out_range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        popped++;
        check("residue", int'(out_residue), e.res);
        check("len_err", int'(out_len_err), e.len);
        check("range_err", int'(out_range_err), e.rng);
      end
    end
  end

  task automatic beat(input int v, input logic l);
    int w;
    w = 0;
    in_valid   = 1'b1;
    in_residue = 7'(v);
    in_last    = l;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) check("ready_timeout", w, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (l) check("latency_out_valid", int'(out_valid), 1);
  endtask

  // n beats of v, with beat index sidx replaced by sv
  task automatic frame(input int n, input int v, input int sidx,
                       input int sv, input int r, input int le,
                       input int re);
    exp_t e;
    e.res = r;
    e.len = le;
    e.rng = re;
    sb.push_back(e);
    for (int i = 0; i < n; i++)
      beat((i == sidx) ? sv : v, i == n - 1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      w++;
      @(negedge clk);
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_residue = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_residue", int'(out_residue), 0);
    check("rst_len_err", int'(out_len_err), 0);
    check("rst_range_err", int'(out_range_err), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    frame(84, 1, -1, 0, 84, 0, 0);
    drain();
    frame(84, 106, -1, 0, 23, 0, 0);
    drain();

    e.res = 103;
    e.len = 1;
    e.rng = 0;
    sb.push_back(e);
    beat(50, 1'b0);
    beat(60, 1'b0);
    beat(100, 1'b1);
    drain();

    frame(84, 0, 40, 120, 13, 0, 1);
    drain();

    out_ready = 1'b0;
    frame(84, 1, -1, 0, 84, 0, 0);
    in_valid   = 1'b1;
    in_residue = 7'd7;
    in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_residue", int'(out_residue), 84);
      check("stall_len_err", int'(out_len_err), 0);
      check("stall_range_err", int'(out_range_err), 0);
      check("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    drain();
    frame(84, 2, -1, 0, 61, 0, 0);
    drain();

    for (int i = 0; i < 10; i++) beat(5, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame(84, 1, -1, 0, 84, 0, 0);
    drain();

    repeat (5) @(posedge clk);
    check("frames_seen", popped, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
